// File: rtl/fifo_read_packer_pkg.sv
// Shared constants and helpers for the FIFO read packer.
// Optional feature macro: FIFO_READ_PACKER_PERF_EN (performance counters).
package fifo_read_packer_pkg;

  localparam int PerfCounterWidth = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PerfCounterWidth-1:0] sat_inc(
    input logic [PerfCounterWidth-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_read_packer_sat_counter.sv
// Saturating event counter; sticks at all-ones once reached.
module fifo_read_packer_sat_counter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  // Count one per cycle with inc_i, holding at the maximum value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (inc_i && !(&count_o)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_read_packer.sv
// FIFO read-side packer: requests words from a CDC FIFO only when the
// returned word is guaranteed a home, and packs Ratio words (lane 0 in LSBs)
// into one wide word on a valid/ready stream.
// Optional feature macro: FIFO_READ_PACKER_PERF_EN adds perf_words_o and
// perf_stall_o saturating counters.
module fifo_read_packer
  import fifo_read_packer_pkg::*;
#(
  parameter int Width = 8,
  parameter int Ratio = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fifo_valid_i,
  output logic                    fifo_req_o,
  input  logic [Width-1:0]        fifo_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
`ifdef FIFO_READ_PACKER_PERF_EN
  output logic [PerfCounterWidth-1:0] perf_words_o,
  output logic [PerfCounterWidth-1:0] perf_stall_o,
`endif
  output logic [Width*Ratio-1:0]  out_data_o
);

  if (Ratio < 1) begin : g_ratio_check
    $error("fifo_read_packer: Ratio must be >= 1");
  end

  localparam int LaneW = (Ratio > 1) ? $clog2(Ratio) : 1;
  typedef logic [LaneW-1:0] lane_t;
  localparam lane_t LastLane = lane_t'(Ratio - 1);

  lane_t                         lane_q;
  logic                          inflight_q;
  logic [Ratio-1:0][Width-1:0]   asm_q;

  lane_t                         req_lane;
  logic                          completing_now;
  logic                          out_free_next;
  logic                          out_xfer;
  logic [Width*Ratio-1:0]        packed_word;

  // Request decision: the last lane may only be requested when the output
  // register is certain to be free by the time that word completes.
  always_comb begin
    completing_now = inflight_q && (lane_q == LastLane);
    if (!inflight_q) begin
      req_lane = lane_q;
    end else if (lane_q == LastLane) begin
      req_lane = '0;
    end else begin
      req_lane = lane_q + 1'b1;
    end
    out_free_next = (!out_valid_o || out_ready_i) && !completing_now;
    fifo_req_o    = fifo_valid_i && ((req_lane != LastLane) || out_free_next);
    out_xfer      = out_valid_o && out_ready_i;
  end

  // Completed word: earlier lanes from the assembly, top lane straight from the FIFO.
  always_comb begin
    packed_word = asm_q;
    packed_word[(Ratio-1)*Width +: Width] = fifo_data_i;
  end

  // Track the in-flight read and the lane its data belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_req_o;
      if (inflight_q) begin
        if (lane_q == LastLane) begin
          lane_q <= '0;
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  // Capture returned FIFO data into its assembly lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q <= '0;
    end else if (inflight_q) begin
      asm_q[lane_q] <= fifo_data_i;
    end
  end

  // Output register: load on completion, clear valid on transfer otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (completing_now) begin
      out_valid_o <= 1'b1;
      out_data_o  <= packed_word;
    end else if (out_xfer) begin
      out_valid_o <= 1'b0;
    end
  end

  // A completion must never find the output occupied and stalled.
  completion_slot_free: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    completing_now |-> (!out_valid_o || out_ready_i)
  );

`ifdef FIFO_READ_PACKER_PERF_EN
  logic stall;
  assign stall = fifo_valid_i && !fifo_req_o;

  fifo_read_packer_sat_counter #(.Width(PerfCounterWidth)) u_perf_words (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (out_xfer),
    .count_o (perf_words_o)
  );

  fifo_read_packer_sat_counter #(.Width(PerfCounterWidth)) u_perf_stall (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (stall),
    .count_o (perf_stall_o)
  );
`endif

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: Ratio=4, Ratio=1 and Ratio=2 instances,
// each fed by a small FIFO read-side model.
module tb_fifo_read_packer;
  import fifo_read_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- Ratio=4 instance ----------------
  logic [7:0]  mem_a [0:31];
  int          ptr_a, avail_a;
  logic        ven_a, ready_a, valid_a, req_a, out_valid_a;
  logic [7:0]  data_a;
  logic [31:0] out_data_a;
  logic [31:0] outq_a [$];
  int          acc_a, stall_a;
  assign valid_a = ven_a && (ptr_a < avail_a);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin ptr_a <= 0; data_a <= '0; end
    else if (req_a && valid_a) begin data_a <= mem_a[ptr_a]; ptr_a <= ptr_a + 1; end

  always @(posedge clk)
    if (!rst_n) begin acc_a <= 0; stall_a <= 0; outq_a.delete(); end
    else begin
      if (req_a && valid_a) acc_a <= acc_a + 1;
      if (valid_a && !req_a) stall_a <= stall_a + 1;
      if (out_valid_a && ready_a) outq_a.push_back(out_data_a);
    end

`ifdef FIFO_READ_PACKER_PERF_EN
  logic [31:0] pw_a, ps_a, pw_b, ps_b, pw_c, ps_c;
`endif

  fifo_read_packer #(.Width(8), .Ratio(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .fifo_valid_i(valid_a), .fifo_req_o(req_a),
    .fifo_data_i(data_a), .out_valid_o(out_valid_a), .out_ready_i(ready_a),
`ifdef FIFO_READ_PACKER_PERF_EN
    .perf_words_o(pw_a), .perf_stall_o(ps_a),
`endif
    .out_data_o(out_data_a)
  );

  // ---------------- Ratio=1 instance ----------------
  logic [7:0] mem_b [0:7];
  int         ptr_b, avail_b;
  logic       ven_b, ready_b, valid_b, req_b, out_valid_b;
  logic [7:0] data_b, out_data_b;
  logic [7:0] outq_b [$];
  int         reqt_b [$];
  int         outt_b [$];
  assign valid_b = ven_b && (ptr_b < avail_b);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin ptr_b <= 0; data_b <= '0; end
    else if (req_b && valid_b) begin data_b <= mem_b[ptr_b]; ptr_b <= ptr_b + 1; end

  always @(posedge clk)
    if (!rst_n) begin outq_b.delete(); reqt_b.delete(); outt_b.delete(); end
    else begin
      if (req_b && valid_b) reqt_b.push_back(cyc);
      if (out_valid_b && ready_b) begin outq_b.push_back(out_data_b); outt_b.push_back(cyc); end
    end

  fifo_read_packer #(.Width(8), .Ratio(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .fifo_valid_i(valid_b), .fifo_req_o(req_b),
    .fifo_data_i(data_b), .out_valid_o(out_valid_b), .out_ready_i(ready_b),
`ifdef FIFO_READ_PACKER_PERF_EN
    .perf_words_o(pw_b), .perf_stall_o(ps_b),
`endif
    .out_data_o(out_data_b)
  );

  // ---------------- Ratio=2 instance ----------------
  logic [7:0]  mem_c [0:7];
  int          ptr_c, avail_c;
  logic        ven_c, ready_c, valid_c, req_c, out_valid_c;
  logic [7:0]  data_c;
  logic [15:0] out_data_c;
  logic [15:0] outq_c [$];
  assign valid_c = ven_c && (ptr_c < avail_c);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin ptr_c <= 0; data_c <= '0; end
    else if (req_c && valid_c) begin data_c <= mem_c[ptr_c]; ptr_c <= ptr_c + 1; end

  always @(posedge clk)
    if (!rst_n) outq_c.delete();
    else if (out_valid_c && ready_c) outq_c.push_back(out_data_c);

  fifo_read_packer #(.Width(8), .Ratio(2)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .fifo_valid_i(valid_c), .fifo_req_o(req_c),
    .fifo_data_i(data_c), .out_valid_o(out_valid_c), .out_ready_i(ready_c),
`ifdef FIFO_READ_PACKER_PERF_EN
    .perf_words_o(pw_c), .perf_stall_o(ps_c),
`endif
    .out_data_o(out_data_c)
  );

  initial begin
    ven_a = 0; ready_a = 0; avail_a = 0;
    ven_b = 0; ready_b = 0; avail_b = 0;
    ven_c = 0; ready_c = 0; avail_c = 0;
    for (int i = 0; i < 32; i++) mem_a[i] = '0;
    for (int i = 0; i < 8; i++) begin mem_b[i] = '0; mem_c[i] = '0; end

    // Reset state
    tick(); tick();
    check("rst_req", {31'd0, req_a}, 32'd0);
    check("rst_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_data", out_data_a, 32'd0);
    rst_n = 1'b1;
    tick();

    // Ratio=4 basic packing with ready high
    mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33; mem_a[3] = 8'h44;
    avail_a = 4; ready_a = 1; ven_a = 1;
    #1;
    check("t1_req0", {31'd0, req_a}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("t1_req%0d", i), {31'd0, req_a}, 32'd1);
    end
    tick();
    check("t1_req_done", {31'd0, req_a}, 32'd0);
    check("t1_valid_lat1", {31'd0, out_valid_a}, 32'd0);
    tick();
    check("t1_valid", {31'd0, out_valid_a}, 32'd1);
    check("t1_data", out_data_a, 32'h44332211);
    tick();
    check("t1_valid_drop", {31'd0, out_valid_a}, 32'd0);

    // Ratio=4 backpressure: 12 words, consumer stalled
    for (int i = 0; i < 12; i++) mem_a[4+i] = 8'h50 + 8'(i);
    ready_a = 0; avail_a = 16;
    repeat (12) tick();
    check("t2_accepted_stalled", acc_a, 32'd11);
    check("t2_valid_held", {31'd0, out_valid_a}, 32'd1);
    check("t2_data_held", out_data_a, 32'h53525150);
    check("t2_req_blocked", {31'd0, req_a}, 32'd0);
    ready_a = 1;
    repeat (20) tick();
    check("t2_accepted_total", acc_a, 32'd16);
    check("t2_out_count", outq_a.size(), 32'd4);
    if (outq_a.size() == 4) begin
      check("t2_word1", outq_a[1], 32'h53525150);
      check("t2_word2", outq_a[2], 32'h57565554);
      check("t2_word3", outq_a[3], 32'h5B5A5958);
    end
`ifdef FIFO_READ_PACKER_PERF_EN
    check("perf_words", pw_a, outq_a.size());
    check("perf_stall", ps_a, stall_a);
`endif

    // Asynchronous reset mid-assembly (2 of 4 lanes filled)
    mem_a[16] = 8'h70; mem_a[17] = 8'h71; avail_a = 18;
    repeat (4) tick();
    check("t5_pre_data", out_data_a, 32'h5B5A5958);
    ven_a = 0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid_a}, 32'd0);
    check("t5_rst_data", out_data_a, 32'd0);
    check("t5_rst_req", {31'd0, req_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_a[0] = 8'hC0; mem_a[1] = 8'hC1; mem_a[2] = 8'hC2; mem_a[3] = 8'hC3;
    avail_a = 4; ven_a = 1;
    repeat (8) tick();
    check("t5_out_count", outq_a.size(), 32'd1);
    if (outq_a.size() >= 1) check("t5_clean_word", outq_a[0], 32'hC3C2C1C0);

    // Ratio=1: stream order and 2-cycle latency
    for (int i = 0; i < 6; i++) mem_b[i] = 8'hD0 + 8'(i);
    avail_b = 6; ready_b = 1; ven_b = 1;
    repeat (20) tick();
    check("r1_out_count", outq_b.size(), 32'd6);
    check("r1_req_count", reqt_b.size(), 32'd6);
    if (outq_b.size() == 6 && reqt_b.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("r1_data%0d", i), {24'd0, outq_b[i]}, {24'd0, 8'hD0 + 8'(i)});
        check($sformatf("r1_lat%0d", i), outt_b[i] - reqt_b[i], 32'd2);
      end
    end

    // Ratio=2 with fifo_valid toggling every cycle
    for (int i = 0; i < 4; i++) mem_c[i] = 8'hA0 + 8'(i);
    avail_c = 4; ready_c = 1;
    for (int i = 0; i < 16; i++) begin
      ven_c = ~ven_c;
      tick();
    end
    check("r2_out_count", outq_c.size(), 32'd2);
    if (outq_c.size() == 2) begin
      check("r2_word0", {16'd0, outq_c[0]}, 32'h0000A1A0);
      check("r2_word1", {16'd0, outq_c[1]}, 32'h0000A3A2);
    end

    // Saturating increment helper near and at the maximum
    check("sat_zero", sat_inc(32'd0), 32'd1);
    check("sat_near_max", sat_inc(32'hFFFF_FFFE), 32'hFFFF_FFFF);
    check("sat_at_max", sat_inc(32'hFFFF_FFFF), 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
